// File: rtl/axi_slave_write_ctrl.sv
// AXI4 slave write-path controller: one burst at a time, each W beat becomes a
// one-cycle memory write strobe, one B response per burst. Optional: AXI_SLV_DECERR_EN.
module axi_slave_write_ctrl #(
    parameter int                ID_W       = 4,
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 16'hFFFF
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ID_W-1:0]       AWID,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [ID_W-1:0]       BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb
);

    localparam int         STRB_W   = DATA_W / 8;
    localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));
    localparam int         EXT_W    = ADDR_W + 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic                incr_q, incr_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    logic                slv_err_q, slv_err_d;
    logic                dec_err_q, dec_err_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic [ADDR_W-1:0]   beat_addr;
    logic                beat_last;
    logic                wlast_bad;
    logic                beat_hs;
    logic                beat_dec;

    always_comb begin
        beat_addr = addr_q & ({ADDR_W{1'b1}} << size_q);
        beat_last = (beat_cnt_q == len_q);
        wlast_bad = (WLAST != beat_last);
        beat_hs   = WVALID && wready_q;
    end

`ifdef AXI_SLV_DECERR_EN
    // Last byte touched by the beat must not exceed the legal window.
    logic [EXT_W-1:0] beat_end;
    always_comb begin
        beat_end = EXT_W'(beat_addr) + (EXT_W'(1) << size_q) - EXT_W'(1);
        beat_dec = (beat_end > EXT_W'(ADDR_LIMIT));
    end
`else
    logic unused_addr_limit;
    assign unused_addr_limit = ^ADDR_LIMIT;
    assign beat_dec = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        incr_d      = incr_q;
        beat_cnt_d  = beat_cnt_q;
        slv_err_d   = slv_err_q;
        dec_err_d   = dec_err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        case (state_q)
            IDLE: begin
                if (AWVALID && awready_q) begin
                    id_d       = AWID;
                    addr_d     = AWADDR;
                    len_d      = AWLEN;
                    size_d     = AWSIZE;
                    incr_d     = (AWBURST == 2'b01);
                    beat_cnt_d = 8'd0;
                    slv_err_d  = AWBURST[1] || (AWSIZE > SIZE_MAX);
                    dec_err_d  = 1'b0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (beat_hs) begin
                    // A WLAST mismatch suppresses the offending beat and all later ones.
                    slv_err_d   = slv_err_q || wlast_bad;
                    dec_err_d   = dec_err_q || beat_dec;
                    mem_we_d    = !slv_err_d && !beat_dec;
                    mem_addr_d  = beat_addr;
                    mem_wdata_d = WDATA;
                    mem_wstrb_d = WSTRB;
                    if (incr_q) begin
                        addr_d = addr_q + (ADDR_W'(1) << size_q);
                    end
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_last) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (bvalid_q && BREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        awready_d = (state_d == IDLE);
        wready_d  = (state_d == DATA);
        bvalid_d  = (state_d == RESP);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            incr_q      <= 1'b0;
            beat_cnt_q  <= '0;
            slv_err_q   <= 1'b0;
            dec_err_q   <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            incr_q      <= incr_d;
            beat_cnt_q  <= beat_cnt_d;
            slv_err_q   <= slv_err_d;
            dec_err_q   <= dec_err_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    // SLVERR outranks DECERR.
    assign BRESP     = slv_err_q ? 2'b10 : (dec_err_q ? 2'b11 : 2'b00);
    assign BID       = id_q;
    assign BVALID    = bvalid_q;
    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule
